// File: rtl/pila_ctrl.sv
// Call/return sequencer for the return-address stack; zero-cycle strobe decode, sticky fault halts the core.
// Optional PILA_CTRL_HWM_EN adds an occupancy high-water-mark output (hwm), cleared only by reset.
module pila_ctrl #(
    parameter  int AW    = 10,
    parameter  int DEPTH = 63,
    localparam int DW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          call,
    input  logic          ret,
    input  logic          clr_fault,
    input  logic [AW-1:0] pc,
    input  logic [AW-1:0] target,
    input  logic [AW-1:0] stack_top,
    output logic          push,
    output logic          pop,
    output logic [AW-1:0] d,
    output logic [1:0]    pc_src,
    output logic [AW-1:0] next_pc,
    output logic [DW-1:0] depth,
`ifdef PILA_CTRL_HWM_EN
    output logic [DW-1:0] hwm,
`endif
    output logic          halt,
    output logic [1:0]    fault
);

    typedef enum logic {RUN = 1'b0, FAULT = 1'b1} state_t;

    localparam logic [1:0] F_NONE = 2'b00;
    localparam logic [1:0] F_OVF  = 2'b01;
    localparam logic [1:0] F_UNF  = 2'b10;
    localparam logic [1:0] F_ILL  = 2'b11;

    localparam logic [1:0] SRC_INC  = 2'b00;
    localparam logic [1:0] SRC_TGT  = 2'b01;
    localparam logic [1:0] SRC_RET  = 2'b10;
    localparam logic [1:0] SRC_HOLD = 2'b11;

    state_t        state, state_next;
    logic [DW-1:0] depth_next;
    logic [1:0]    fault_next;
    logic          faulting;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= RUN;
            depth <= '0;
            fault <= F_NONE;
        end else begin
            state <= state_next;
            depth <= depth_next;
            fault <= fault_next;
        end
    end

    always_comb begin
        state_next = state;
        depth_next = depth;
        fault_next = fault;
        case (state)
            RUN: begin
                if (call && ret) begin
                    state_next = FAULT;
                    fault_next = F_ILL;
                end else if (call) begin
                    if (depth == DW'(DEPTH)) begin
                        state_next = FAULT;
                        fault_next = F_OVF;
                    end else begin
                        depth_next = depth + DW'(1);
                    end
                end else if (ret) begin
                    if (depth == '0) begin
                        state_next = FAULT;
                        fault_next = F_UNF;
                    end else begin
                        depth_next = depth - DW'(1);
                    end
                end
            end
            FAULT: begin
                if (clr_fault) begin
                    state_next = RUN;
                    fault_next = F_NONE;
                end
            end
            default: begin
                state_next = RUN;
                fault_next = F_NONE;
            end
        endcase
    end

    // A cycle that is about to fault already holds the PC and asserts halt.
    assign faulting = (state == RUN) && (state_next == FAULT);

    always_comb begin
        push    = 1'b0;
        pop     = 1'b0;
        pc_src  = SRC_HOLD;
        next_pc = pc;
        halt    = 1'b1;
        if (state == RUN && !faulting) begin
            halt = 1'b0;
            if (call) begin
                push    = 1'b1;
                pc_src  = SRC_TGT;
                next_pc = target;
            end else if (ret) begin
                pop     = 1'b1;
                pc_src  = SRC_RET;
                next_pc = stack_top;
            end else begin
                pc_src  = SRC_INC;
                next_pc = pc + AW'(1);
            end
        end
    end

    assign d = pc;

`ifdef PILA_CTRL_HWM_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hwm <= '0;
        end else if (depth_next > hwm) begin
            hwm <= depth_next;
        end
    end
`endif

endmodule

// File: doc/pila_ctrl.md
# pila_ctrl

Call/return sequencer that drives the return-address stack (`pila`) from the CPU side. It decodes the control unit's `call`/`ret` strobes into `push`/`pop`, selects the next-PC source, and tracks stack occupancy in its own depth counter. Overflow, underflow and illegal call+ret combinations are caught and latched as a sticky fault that halts the core until software or the bench clears it. It sits between the control unit, the PC mux and `pila` in the extended single-cycle CPU.

## Interface
- `AW`, 10, address/PC width; must match `pila` data width.
- `DEPTH`, 63, usable stack entries: the 64-word stack minus slot 0, which is never written.
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-low (0 = reset); one clock, no other reset.
- `call`  in  1  decoded call instruction this cycle.
- `ret`  in  1  decoded return instruction this cycle.
- `clr_fault`  in  1  clears a latched fault (ignored while in RUN).
- `pc`  in  AW  address of current instruction.
- `target`  in  AW  call destination.
- `stack_top`  in  AW  `pila.out`, i.e. the return address already incremented.
- `push`  out  1  to `pila.push`.
- `pop`  out  1  to `pila.pop`.
- `d`  out  AW  to `pila.d`; equals `pc`.
- `pc_src`  out  2  00 = pc+1, 01 = target, 10 = return, 11 = hold.
- `next_pc`  out  AW  address for the PC mux per `pc_src`.
- `depth`  out  $clog2(DEPTH+1)  current occupancy.
- `halt`  out  1  core must not advance the PC.
- `fault`  out  2  00 none, 01 overflow, 10 underflow, 11 illegal.

## Operation
- State machine with two states: RUN and FAULT. Reset enters RUN.
- In RUN, `call` alone with `depth < DEPTH` gives `push=1` and `pc_src=01`. `next_pc` = `target`. `depth` increments at the edge.
- In RUN, `ret` alone with `depth > 0` gives `pop=1` and `pc_src=10`. `next_pc` = `stack_top`. `depth` decrements at the edge.
- In RUN with neither strobe: `pc_src=00`, `next_pc` = `pc+1` (mod 2^AW, wraps from all-ones to 0).
- `call` with `depth == DEPTH` is an overflow. `fault` is latched to 01 and the state goes to FAULT.
- `ret` with `depth == 0` is an underflow. `fault` is latched to 10 and the state goes to FAULT.
- `call` and `ret` in the same cycle is illegal. `fault` is latched to 11 and the state goes to FAULT.
- On any faulting cycle: `push=pop=0`, `pc_src=11`, `next_pc=pc`, and `depth` is unchanged.
- In FAULT: `push=pop=0`, `pc_src=11`, `halt=1`, and `call`/`ret` are ignored.
- In FAULT, `clr_fault=1` returns the state to RUN and sets `fault` to 00 at the next edge. `depth` is preserved, so the stack contents stay valid.
- `push`, `pop`, `pc_src`, `next_pc`, `d` and `halt` are combinational from the inputs and the registered state. `depth`, `fault` and the state are registered.

## Timing
- Reset (async, `reset=0`): state RUN, `depth=0`, `fault=00`. Combinational outputs follow: `push=0`, `pop=0`, `halt=0`, `pc_src=00`.
- Zero-cycle latency from strobe to `push`/`pop`/`pc_src`; `pila` samples them at the same edge.
- A return uses `stack_top` in the same cycle `pop` is high. `pila` decrements its pointer at that edge.
- `halt` rises combinationally in the faulting cycle and stays high until the edge that samples `clr_fault=1`.
- Reset asserted mid-call clears `depth` immediately. This block does not reset the `pila` pointer: `pila` must be reset from the same source.

## Configuration
- Macro: `PILA_CTRL_HWM_EN`.
- Defined: adds output `hwm` (same width as `depth`), reset to 0. At every edge `hwm` takes `max(hwm, depth_next)`. `hwm` is cleared only by reset, not by `clr_fault`.
- Undefined: no `hwm` port or register; all other behaviour is identical.

## Test plan
- Reset, then `call` with `pc=0x010`, `target=0x100` -> `push=1`, `pc_src=01`, `next_pc=0x100`, `d=0x010`; `depth=1` after the edge.
- Next cycle, `ret` with `stack_top=0x011` -> `pop=1`, `pc_src=10`, `next_pc=0x011`; `depth=0` after the edge.
- 63 consecutive calls, then a 64th -> the 64th gives `push=0`, `fault=01`, `halt=1`, `depth=63`; `clr_fault` -> RUN with `depth=63`.
- `ret` at `depth=0` -> `pop=0`, `fault=10`, `halt=1`; a following `call` is ignored until `clr_fault`.
- `call` and `ret` together at `depth=5` -> `fault=11`, `depth` stays 5, no push/pop.
- `PILA_CTRL_HWM_EN` defined: 3 calls, 3 returns, 1 call -> `hwm=3`, `depth=1`.
